alu_result_reader: RTL

- Downstream stage of the ALU/result-memory pair. The ALU writes 9-bit results into the 16-deep single-port block RAM; this block reads them back.
- On `start`, walks a window of RAM addresses, waiting out the RAM read latency for each one.
- Presents each word on a valid/ready stream and keeps a running sum and maximum of the words transferred.
- Top level drives the RAM write enable low while `busy` is high and muxes `mem_addr` onto the RAM address.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_result_reader_if.sv | 17 +
 rtl/alu_result_reader_rd_stats.sv | 30 +++
 rtl/alu_result_reader.sv | 120 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: word/address widths, reader FSM
// states and the accumulator width helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package alu_pkg;

  localparam int DATA_W = 9;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Sum of 2**addr_w words of data_w bits never exceeds data_w+addr_w bits.
  function automatic int sum_width(input int data_w, input int addr_w);
    return data_w + addr_w;
  endfunction

endpackage

// File: rtl/alu_result_reader_if.sv
// Valid/ready result stream out of the reader: word, its RAM address, handshake.
// Latency: n/a (wires only). Backpressure: master holds m_data/m_index while m_valid & !m_ready.
// Ports: master drives m_data, m_index, m_valid and samples m_ready; slave is the mirror.
interface alu_result_reader_if #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int ADDR_W = alu_pkg::ADDR_W
);

  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_index;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_index, output m_valid, input m_ready);
  modport slave  (input m_data, input m_index, input m_valid, output m_ready);

endinterface

// File: rtl/alu_result_reader_rd_stats.sv
// Running unsigned sum and maximum of a word stream, with synchronous clear.
// Latency: results visible the clock after upd. Backpressure: none, upd is the only qualifier.
// Ports: clk, rst (async high); clr zeroes both results; upd folds din in; sum, max registered.
module rd_stats #(
  parameter int DATA_W = 9,
  parameter int SUM_W  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              upd,
  input  logic [DATA_W-1:0] din,
  output logic [SUM_W-1:0]  sum,
  output logic [DATA_W-1:0] max
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      max <= '0;
    end else if (clr) begin
      sum <= '0;
      max <= '0;
    end else if (upd) begin
      sum <= sum + SUM_W'(din);
      if (din > max) max <= din;
    end
  end

endmodule

// File: rtl/alu_result_reader.sv
// Sweeps a window of result-RAM addresses and streams each word out with sum/max stats.
// Latency: start accept to m_valid = READ_LAT+1 clocks; one word per READ_LAT+2 clocks best case.
// Backpressure: m_valid/m_data/m_index hold until m_ready; no prefetch, so RAM reads stall too.
// Ports: clk, rst (async high); start/first_addr/count request a sweep; mem_addr/mem_dout
// talk to the RAM read port; m (master) is the output stream; sum, max, busy, done status.
module alu_result_reader #(
  parameter int DATA_W   = alu_pkg::DATA_W,
  parameter int ADDR_W   = alu_pkg::ADDR_W,
  parameter int READ_LAT = 1,                  // RAM addr-to-douta clocks, 1..3
  parameter int SUM_W    = alu_pkg::sum_width(DATA_W, ADDR_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    first_addr,
  input  logic [ADDR_W:0]      count,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_dout,
  alu_result_reader_if.master  m,
  output logic [SUM_W-1:0]     sum,
  output logic [DATA_W-1:0]    max,
  output logic                 busy,
  output logic                 done
);

  import alu_pkg::*;

  localparam logic [1:0]    LAT = 2'(READ_LAT);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_t              state;
  logic [ADDR_W:0]     remaining;
  logic [1:0]          wait_cnt;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   index_q;
  logic                valid_q;
  logic                xfer;
  logic                stats_clr;

  assign m.m_data  = data_q;
  assign m.m_index = index_q;
  assign m.m_valid = valid_q;

  assign xfer      = valid_q & m.m_ready;
  // Any accepted start (including count=0) clears the stats.
  assign stats_clr = (state == IDLE) & start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      data_q    <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              mem_addr  <= first_addr;
              remaining <= count;
              wait_cnt  <= LAT;
              busy      <= 1'b1;
              state     <= WAIT;
            end else begin
              // Empty sweep: nothing to read, just signal completion.
              done <= 1'b1;
            end
          end
        end
        WAIT: begin
          // READ_LAT edges for the RAM to produce douta, then one capture edge.
          if (wait_cnt == 2'd0) begin
            data_q  <= mem_dout;
            index_q <= mem_addr;
            valid_q <= 1'b1;
            state   <= PRESENT;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        PRESENT: begin
          if (xfer) begin
            valid_q   <= 1'b0;
            remaining <= remaining - ONE;
            if (remaining != ONE) begin
              mem_addr <= mem_addr + ADDR_W'(1);   // wraps modulo depth
              wait_cnt <= LAT;
              state    <= WAIT;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rd_stats #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_stats (
    .clk (clk),
    .rst (rst),
    .clr (stats_clr),
    .upd (xfer),
    .din (data_q),
    .sum (sum),
    .max (max)
  );

endmodule
